// File: rtl/matrix_bank_if.sv
// Bundle of the matrix_bank bus signals: read ports, full write, row-serial load, clear.
// The design uses the slave modport; the driving side (decoder or a bench) uses master.
interface matrix_bank_if #(
    parameter int DIM     = 4,
    parameter int ELEM_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CONST_W = 16
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int ROW_W = DIM * ELEM_W;
    localparam int MAT_W = DIM * DIM * ELEM_W;

    logic [IDX_W-1:0]   rd1_idx;
    logic [IDX_W-1:0]   rd2_idx;
    logic               gen_en;
    logic [CONST_W-1:0] constant;
    logic [MAT_W-1:0]   data1;
    logic [MAT_W-1:0]   data2;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [MAT_W-1:0]   wr_data;
    logic               wr_err;
    logic               ld_start;
    logic [IDX_W-1:0]   ld_idx;
    logic               row_valid;
    logic [ROW_W-1:0]   row_data;
    logic               row_ready;
    logic               clr_start;
    logic               busy;
    logic               op_done;

    modport master (
        output rd1_idx, rd2_idx, gen_en, constant,
        output wr_en, wr_idx, wr_data,
        output ld_start, ld_idx, row_valid, row_data,
        output clr_start,
        input  data1, data2, wr_err, row_ready, busy, op_done
    );

    modport slave (
        input  rd1_idx, rd2_idx, gen_en, constant,
        input  wr_en, wr_idx, wr_data,
        input  ld_start, ld_idx, row_valid, row_data,
        input  clr_start,
        output data1, data2, wr_err, row_ready, busy, op_done
    );
endinterface

// File: rtl/matrix_bank.sv
// DEPTH-entry bank of DIM x DIM matrices with two registered read ports, full write,
// row-serial load and bulk clear. Define MATRIX_BANK_BYPASS_EN for write-to-read bypass.
module matrix_bank #(
    parameter int DIM     = 4,
    parameter int ELEM_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CONST_W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    matrix_bank_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int RC_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int ROW_W = DIM * ELEM_W;
    localparam int MAT_W = DIM * DIM * ELEM_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RC_W-1:0]  rcnt;
    logic [IDX_W-1:0] ld_tgt;
    logic [IDX_W-1:0] clr_cnt;
    logic             op_done_q;
    logic             wr_err_q;

    logic             busy_c;
    logic             ready_c;
    logic             beat;
    logic             last_beat;
    logic             last_clear;
    logic             done_c;

    logic             we;
    logic [IDX_W-1:0] we_idx;
    logic [MAT_W-1:0] we_data;
    logic [MAT_W-1:0] row_merged;
    logic [MAT_W-1:0] const_mat;
    logic [MAT_W-1:0] rd1_val;
    logic [MAT_W-1:0] rd2_val;
    logic [MAT_W-1:0] data1_q;
    logic [MAT_W-1:0] data2_q;

    logic [MAT_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Clear wins over a simultaneous load request; starts are only honoured in IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_next = CLEAR;
                end else if (bus.ld_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (last_clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c     = (state != IDLE);
        ready_c    = (state == LOAD);
        beat       = ready_c && bus.row_valid;
        last_beat  = beat && (rcnt == RC_W'(DIM - 1));
        last_clear = (state == CLEAR) && (clr_cnt == IDX_W'(DEPTH - 1));
        done_c     = last_beat || last_clear;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rcnt      <= '0;
            ld_tgt    <= '0;
            clr_cnt   <= '0;
            op_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            op_done_q <= done_c;
            wr_err_q  <= bus.wr_en && busy_c;
            unique case (state)
                IDLE: begin
                    rcnt    <= '0;
                    clr_cnt <= '0;
                    if (bus.ld_start) begin
                        ld_tgt <= bus.ld_idx;
                    end
                end
                LOAD: begin
                    if (last_beat) begin
                        rcnt <= '0;
                    end else if (beat) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
                default: begin
                    rcnt    <= '0;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    // A row beat rewrites the whole entry with only row rcnt replaced.
    always_comb begin
        row_merged = mem[ld_tgt];
        for (int r = 0; r < DIM; r++) begin
            if (RC_W'(r) == rcnt) begin
                row_merged[r*ROW_W +: ROW_W] = bus.row_data;
            end
        end
    end

    always_comb begin
        we      = 1'b0;
        we_idx  = bus.wr_idx;
        we_data = bus.wr_data;
        unique case (state)
            IDLE: begin
                we = bus.wr_en;
            end
            LOAD: begin
                we      = beat;
                we_idx  = ld_tgt;
                we_data = row_merged;
            end
            CLEAR: begin
                we      = 1'b1;
                we_idx  = clr_cnt;
                we_data = '0;
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[we_idx] <= we_data;
        end
    end

    // Read selection: with bypass, a read of the entry being written sees the new value.
    always_comb begin
        const_mat = {(DIM * DIM){ELEM_W'(bus.constant)}};
`ifdef MATRIX_BANK_BYPASS_EN
        rd1_val = (we && (we_idx == bus.rd1_idx)) ? we_data : mem[bus.rd1_idx];
        rd2_val = (we && (we_idx == bus.rd2_idx)) ? we_data : mem[bus.rd2_idx];
`else
        rd1_val = mem[bus.rd1_idx];
        rd2_val = mem[bus.rd2_idx];
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            data1_q <= rd1_val;
            data2_q <= bus.gen_en ? const_mat : rd2_val;
        end
    end

    assign bus.data1     = data1_q;
    assign bus.data2     = data2_q;
    assign bus.busy      = busy_c;
    assign bus.row_ready = ready_c;
    assign bus.op_done   = op_done_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: tb/tb_matrix_bank.sv
// Directed self-checking bench for matrix_bank: reset, full write, constant broadcast,
// row load with stall and dropped write, clear priority over load, reset abort.
module tb_matrix_bank;
    localparam int DIM     = 4;
    localparam int ELEM_W  = 32;
    localparam int DEPTH   = 8;
    localparam int CONST_W = 16;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int ROW_W   = DIM * ELEM_W;
    localparam int MAT_W   = DIM * DIM * ELEM_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [MAT_W-1:0] ramp_m;
    logic [MAT_W-1:0] exp_m;
    logic [MAT_W-1:0] exp_c;

    matrix_bank_if #(.DIM(DIM), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .CONST_W(CONST_W)) bus ();

    matrix_bank #(.DIM(DIM), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .CONST_W(CONST_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MAT_W-1:0] fill_val(input int i);
        logic [MAT_W-1:0] m;
        for (int e = 0; e < DIM * DIM; e++) begin
            m[e*ELEM_W +: ELEM_W] = ELEM_W'(32'h0A000000 + (i << 8) + e);
        end
        return m;
    endfunction

    function automatic logic [ROW_W-1:0] load_row(input int r);
        return {DIM{ELEM_W'(32'h11111111 * (r + 1))}};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.op_done !== 1'b0 || bus.row_ready !== 1'b0 || bus.wr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status busy=%b op_done=%b row_ready=%b wr_err=%b expected all 0",
                     bus.busy, bus.op_done, bus.row_ready, bus.wr_err);
        end
        checks++;
        if (bus.data1 !== '0 || bus.data2 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data data1=%h data2=%h expected 0", bus.data1, bus.data2);
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd1_idx = IDX_W'(i);
            bus.rd2_idx = IDX_W'(DEPTH - 1 - i);
            tick();
            checks++;
            if (bus.data1 !== '0 || bus.data2 !== '0) begin
                errors++;
                $display("[TB] FAIL reset_read[%0d] data1=%h data2=%h expected 0", i, bus.data1, bus.data2);
            end
        end
    endtask

    task automatic test_full_write();
        logic [ELEM_W-1:0] same_exp;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                ramp_m[(r*DIM+c)*ELEM_W +: ELEM_W] = ELEM_W'(r * DIM + c);
            end
        end
`ifdef MATRIX_BANK_BYPASS_EN
        same_exp = 32'd9;
`else
        same_exp = 32'd0;
`endif
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 3'd3;
        bus.wr_data = ramp_m;
        bus.rd1_idx = 3'd3;
        bus.rd2_idx = 3'd3;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.data1[(2*DIM+1)*ELEM_W +: ELEM_W] !== same_exp) begin
            errors++;
            $display("[TB] FAIL write_same_cycle elem[2][1]=%0d expected %0d",
                     bus.data1[(2*DIM+1)*ELEM_W +: ELEM_W], same_exp);
        end
        tick();
        checks++;
        if (bus.data1[(2*DIM+1)*ELEM_W +: ELEM_W] !== 32'd9) begin
            errors++;
            $display("[TB] FAIL write_next_elem elem[2][1]=%0d expected 9", bus.data1[(2*DIM+1)*ELEM_W +: ELEM_W]);
        end
        checks++;
        if (bus.data1 !== ramp_m || bus.data2 !== ramp_m) begin
            errors++;
            $display("[TB] FAIL write_next_full data1=%h data2=%h expected %h", bus.data1, bus.data2, ramp_m);
        end
    endtask

    task automatic test_const();
        exp_c = {(DIM * DIM){32'h0000BEEF}};
        bus.gen_en   = 1'b1;
        bus.constant = 16'hBEEF;
        bus.rd1_idx  = 3'd3;
        bus.rd2_idx  = 3'd3;
        tick();
        checks++;
        if (bus.data2 !== exp_c) begin
            errors++;
            $display("[TB] FAIL const_idx3 data2=%h expected %h", bus.data2, exp_c);
        end
        checks++;
        if (bus.data1 !== ramp_m) begin
            errors++;
            $display("[TB] FAIL const_port1 data1=%h expected %h", bus.data1, ramp_m);
        end
        bus.rd2_idx = 3'd6;
        tick();
        checks++;
        if (bus.data2 !== exp_c) begin
            errors++;
            $display("[TB] FAIL const_idx6 data2=%h expected %h", bus.data2, exp_c);
        end
        bus.gen_en = 1'b0;
        tick();
        checks++;
        if (bus.data2 !== '0) begin
            errors++;
            $display("[TB] FAIL const_off data2=%h expected 0", bus.data2);
        end
    endtask

    task automatic test_load();
        bus.ld_start = 1'b1;
        bus.ld_idx   = 3'd5;
        tick();
        bus.ld_start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.row_ready !== 1'b1 || bus.op_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_start busy=%b row_ready=%b op_done=%b expected 1 1 0",
                     bus.busy, bus.row_ready, bus.op_done);
        end
        bus.row_valid = 1'b1;
        bus.row_data  = load_row(0);
        tick();
        bus.row_valid = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_idx    = 3'd0;
        bus.wr_data   = '1;
        tick();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_err !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_wr_err wr_err=%b busy=%b expected 1 1", bus.wr_err, bus.busy);
        end
        bus.row_valid = 1'b1;
        bus.row_data  = load_row(1);
        tick();
        checks++;
        if (bus.wr_err !== 1'b0 || bus.busy !== 1'b1 || bus.op_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_mid wr_err=%b busy=%b op_done=%b expected 0 1 0",
                     bus.wr_err, bus.busy, bus.op_done);
        end
        bus.row_data = load_row(2);
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_busy5 busy=%b expected 1", bus.busy);
        end
        bus.row_data = load_row(3);
        tick();
        bus.row_valid = 1'b0;
        checks++;
        if (bus.op_done !== 1'b1 || bus.busy !== 1'b0 || bus.row_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_done op_done=%b busy=%b row_ready=%b expected 1 0 0",
                     bus.op_done, bus.busy, bus.row_ready);
        end
        bus.rd1_idx = 3'd5;
        bus.rd2_idx = 3'd0;
        tick();
        checks++;
        if (bus.op_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_done_pulse op_done=%b expected 0", bus.op_done);
        end
        for (int r = 0; r < DIM; r++) begin
            exp_m[r*ROW_W +: ROW_W] = load_row(r);
        end
        checks++;
        if (bus.data1 !== exp_m) begin
            errors++;
            $display("[TB] FAIL load_contents data1=%h expected %h", bus.data1, exp_m);
        end
        checks++;
        if (bus.data2 !== '0) begin
            errors++;
            $display("[TB] FAIL load_dropped_write data2=%h expected 0", bus.data2);
        end
    endtask

    task automatic test_clear_priority();
        int  cycles;
        bit  done;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_idx  = IDX_W'(i);
            bus.wr_data = fill_val(i);
            tick();
        end
        bus.wr_en     = 1'b0;
        bus.clr_start = 1'b1;
        bus.ld_start  = 1'b1;
        bus.ld_idx    = 3'd2;
        bus.rd1_idx   = 3'd7;
        tick();
        bus.clr_start = 1'b0;
        bus.ld_start  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.row_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_start busy=%b row_ready=%b expected 1 0", bus.busy, bus.row_ready);
        end
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
            if (cycles == 1) begin
                checks++;
                if (bus.data1 !== fill_val(7)) begin
                    errors++;
                    $display("[TB] FAIL clear_old_contents data1=%h expected %h", bus.data1, fill_val(7));
                end
            end
            if (bus.op_done === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || cycles != DEPTH) begin
            errors++;
            $display("[TB] FAIL clear_latency op_done after %0d cycles expected %0d", cycles, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd1_idx = IDX_W'(i);
            bus.rd2_idx = IDX_W'(i);
            tick();
            checks++;
            if (bus.data1 !== '0 || bus.data2 !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clear_read[%0d] data1=%h data2=%h busy=%b expected 0 0 0",
                         i, bus.data1, bus.data2, bus.busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.ld_start = 1'b1;
        bus.ld_idx   = 3'd6;
        tick();
        bus.ld_start  = 1'b0;
        bus.row_valid = 1'b1;
        bus.row_data  = load_row(0);
        tick();
        bus.row_data = load_row(1);
        tick();
        bus.row_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.op_done !== 1'b0 || bus.row_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_status busy=%b op_done=%b row_ready=%b expected 0 0 0",
                     bus.busy, bus.op_done, bus.row_ready);
        end
        rst = 1'b0;
        bus.rd1_idx = 3'd6;
        tick();
        checks++;
        if (bus.op_done !== 1'b0 || bus.data1 !== '0) begin
            errors++;
            $display("[TB] FAIL abort_entry op_done=%b data1=%h expected 0 0", bus.op_done, bus.data1);
        end
    endtask

    initial begin
        bus.rd1_idx   = '0;
        bus.rd2_idx   = '0;
        bus.gen_en    = 1'b0;
        bus.constant  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_data   = '0;
        bus.ld_start  = 1'b0;
        bus.ld_idx    = '0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.clr_start = 1'b0;
        test_reset();
        test_full_write();
        test_const();
        test_load();
        test_clear_priority();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matrix_bank.md
# matrix_bank

Parametrised matrix register bank for the matrix datapath: DEPTH entries, each a DIM×DIM matrix of ELEM_W-bit elements.
- Two registered read ports; read port 2 can instead broadcast a zero-extended constant to every element.
- Entries are written by a single-cycle full-matrix write, by a handshaked row-serial load engine, or by a bulk-clear engine.
- Sits between the instruction decoder and the matrix ALU, alongside the existing data memory.

## Interface
Parameters:
- DIM, 4, matrix dimension (rows = columns)
- ELEM_W, 32, element width in bits
- DEPTH, 8, number of matrix entries; power of two ≥2; IDX_W = $clog2(DEPTH)
- CONST_W, 16, constant width; must be ≤ ELEM_W

Ports (reset is synchronous, active-high):
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- rd1_idx  in  IDX_W  read port 1 entry index
- rd2_idx  in  IDX_W  read port 2 entry index
- gen_en  in  1  port 2 returns constant matrix instead of mem[rd2_idx]
- constant  in  CONST_W  constant for broadcast
- data1  out  DIM*DIM*ELEM_W  registered read data, port 1; element [r][c] at bit offset (r*DIM+c)*ELEM_W
- data2  out  DIM*DIM*ELEM_W  registered read data, port 2; same layout as data1
- wr_en  in  1  full-matrix write request
- wr_idx  in  IDX_W  full-matrix write index
- wr_data  in  DIM*DIM*ELEM_W  full-matrix write data
- wr_err  out  1  one-cycle pulse: wr_en dropped because the bank was busy
- ld_start  in  1  start row-serial load
- ld_idx  in  IDX_W  target entry for the load
- row_valid  in  1  row beat valid
- row_data  in  DIM*ELEM_W  one row; element c at bit offset c*ELEM_W
- row_ready  out  1  engine accepts a row this cycle
- clr_start  in  1  start bulk clear of all entries
- busy  out  1  load or clear in progress
- op_done  out  1  one-cycle pulse when a load or clear completes

## Operation
- FSM states: IDLE, LOAD, CLEAR.
  - IDLE→CLEAR on clr_start.
  - IDLE→LOAD on ld_start.
  - If clr_start and ld_start are asserted together, CLEAR wins and the load is dropped.
  - ld_start and clr_start are ignored outside IDLE.
- LOAD:
  - ld_idx is latched on entry.
  - row_ready=1 throughout LOAD.
  - Each row_valid&&row_ready beat writes row_data to row rcnt of the latched entry, then rcnt increments.
  - After the beat with rcnt=DIM-1, the FSM returns to IDLE.
  - Unwritten rows are never touched; the partial load remains on reset-free abort only (none exists).
- CLEAR: zeroes entry k at cycle k, k = 0..DEPTH-1, then returns to IDLE.
- Full write:
  - When wr_en=1 and the FSM is in IDLE at the sampling edge, mem[wr_idx] ← wr_data.
  - When wr_en=1 and busy=1, no write occurs and wr_err pulses the next cycle.
- Reads:
  - data1 ← mem[rd1_idx] at every edge.
  - data2 ← gen_en ? constant matrix : mem[rd2_idx].
  - Constant matrix: every element = {(ELEM_W-CONST_W) zeros, constant}.
- Reads are legal in every state. During CLEAR, entries not yet cleared return their old contents.
- Reset:
  - All mem entries = 0; data1 = data2 = 0; busy = row_ready = op_done = wr_err = 0; FSM = IDLE; rcnt = 0.
  - RST asserted mid-LOAD or mid-CLEAR aborts the operation; no op_done is produced.

## Timing
- Read latency: 1 cycle; the index is sampled at edge N and data is valid after edge N.
- ld_start sampled at edge N: busy=row_ready=1 after edge N.
- The first beat can be accepted at edge N+1; the minimum load is DIM cycles.
- The last row is written at edge M. Then op_done=1, busy=0, and row_ready=0 during cycle M+1 only.
- clr_start sampled at edge N: busy=1 after edge N.
- Clear: entries 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH; op_done=1 after edge N+DEPTH.
- A new op may start at the edge where op_done=1, because the FSM is already IDLE.
- Read and write of the same entry in the same cycle (full write, or row beat): see Configuration.

## Configuration
- MATRIX_BANK_BYPASS_EN defined:
  - A read sampled in the same cycle as a write to the same index returns the post-write value.
  - For a full write, the read returns wr_data.
  - For a row beat, the read returns the stored matrix with row rcnt replaced by row_data.
  - During CLEAR, the read returns zero for entry k.
  - gen_en on port 2 still takes priority over bypass.
- Undefined: the read returns the pre-write contents. The write is visible on the following read.

## Test plan
- Reset, then read all entries -> data1=data2=0, busy=0, op_done=0.
- wr_en idx3 with element [r][c]=r*DIM+c, then rd1_idx=3 next cycle -> data1 element[2][1]=9. Same-cycle read: 9 if MATRIX_BANK_BYPASS_EN is defined, else 0.
- gen_en=1, constant=0xBEEF -> every data2 element = 0x0000BEEF regardless of rd2_idx.
- Load with ld_start idx5 and 4 rows 0x11.., with row_valid deasserted on beat 2 -> busy for 5 cycles after start, op_done single pulse, mem[5] rows correct. A wr_en during the load -> wr_err pulse, no write.
- clr_start and ld_start asserted together after filling all entries -> clear runs, op_done after DEPTH=8 cycles, all reads 0, no load performed.
- RST after 2 rows of a load -> busy=0, mem[ld_idx]=0, no op_done pulse.
